// File: rtl/snitch_fpu_share_arbiter_pkg.sv
// rtl/snitch_fpu_share_arbiter_pkg.sv - shared widths and grant state for the FPU share arbiter
package snitch_fpu_share_arbiter_pkg;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // A single requester still gets one id bit so the tag split stays uniform.
  function automatic int unsigned fpu_share_id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned fpu_share_cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/snitch_fpu_share_arbiter_rr.sv
// rtl/snitch_fpu_share_arbiter_rr.sv - round-robin arbiter whose grant is held until the handshake
module snitch_fpu_share_arbiter_rr
  import snitch_fpu_share_arbiter_pkg::*;
#(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned IdWidth = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  req_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [IdWidth-1:0] id_o
);

  arb_state_e         r_state;
  arb_state_e         w_state_next;
  logic [IdWidth-1:0] r_rr;
  logic [IdWidth-1:0] r_lock_id;
  logic [IdWidth-1:0] w_rr_next;
  logic [IdWidth-1:0] w_lock_id_next;
  logic [IdWidth-1:0] w_winner;
  logic               w_any;
  int unsigned        w_dist;
  int unsigned        w_best;

  // Winner is the requester at the smallest wrap-around distance from the pointer.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_best   = NumReq;
    w_dist   = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_dist = (32'(i) + NumReq - 32'(r_rr)) % NumReq;
      if (req_i[i] && (w_dist < w_best)) begin
        w_any    = 1'b1;
        w_best   = w_dist;
        w_winner = IdWidth'(i);
      end
    end
  end

  always_comb begin
    valid_o        = (r_state == ARB_LOCKED) || w_any;
    id_o           = (r_state == ARB_LOCKED) ? r_lock_id : w_winner;
    w_state_next   = r_state;
    w_rr_next      = r_rr;
    w_lock_id_next = r_lock_id;
    if (valid_o && ready_i) begin
      w_state_next = ARB_OPEN;
      w_rr_next    = IdWidth'((32'(id_o) + 1) % NumReq);
    end else if (valid_o) begin
      w_state_next   = ARB_LOCKED;
      w_lock_id_next = id_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ARB_OPEN;
      r_rr      <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rr      <= w_rr_next;
      r_lock_id <= w_lock_id_next;
    end
  end

endmodule

// File: rtl/snitch_fpu_share_arbiter.sv
// rtl/snitch_fpu_share_arbiter.sv - shares one FPU between requesters with tag-routed responses
module snitch_fpu_share_arbiter
  import snitch_fpu_share_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned ReqDataWidth   = 256,
  parameter int unsigned RspDataWidth   = 69,
  parameter int unsigned TagWidth       = 7,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic [NumReq-1:0]                                         req_valid_i,
  output logic [NumReq-1:0]                                         req_ready_o,
  input  logic [NumReq-1:0][ReqDataWidth-1:0]                       req_data_i,
  input  logic [NumReq-1:0][TagWidth-fpu_share_id_width(NumReq)-1:0] req_tag_i,
  output logic [NumReq-1:0]                                         rsp_valid_o,
  input  logic [NumReq-1:0]                                         rsp_ready_i,
  output logic [RspDataWidth-1:0]                                   rsp_data_o,
  output logic [TagWidth-fpu_share_id_width(NumReq)-1:0]            rsp_tag_o,
  output logic                                                      fpu_valid_o,
  input  logic                                                      fpu_ready_i,
  output logic [ReqDataWidth-1:0]                                   fpu_data_o,
  output logic [TagWidth-1:0]                                       fpu_tag_o,
  input  logic                                                      fpu_rsp_valid_i,
  output logic                                                      fpu_rsp_ready_o,
  input  logic [RspDataWidth-1:0]                                   fpu_rsp_data_i,
  input  logic [TagWidth-1:0]                                       fpu_rsp_tag_i,
  output logic [NumReq-1:0]                                         busy_o
);

  localparam int unsigned IdWidth       = fpu_share_id_width(NumReq);
  localparam int unsigned LocalTagWidth = TagWidth - IdWidth;
  localparam int unsigned CntWidth      = fpu_share_cnt_width(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [NumReq-1:0]   w_eligible;
  logic                w_arb_valid;
  logic [IdWidth-1:0]  w_grant;
  logic                w_req_fire;
  logic [IdWidth-1:0]  w_rsp_id;
  logic                w_rsp_id_ok;
  logic                w_rsp_fire;
  logic [CntWidth-1:0] r_cnt [NumReq];

  snitch_fpu_share_arbiter_rr #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (w_eligible),
    .ready_i (fpu_ready_i),
    .valid_o (w_arb_valid),
    .id_o    (w_grant)
  );

  assign fpu_valid_o = w_arb_valid & ~rst_i;
  assign fpu_data_o  = req_data_i[w_grant];
  assign fpu_tag_o   = {w_grant, req_tag_i[w_grant]};
  assign w_req_fire  = fpu_valid_o & fpu_ready_i;

  // Out-of-range ids cannot be routed, so they are accepted and dropped.
  assign w_rsp_id        = fpu_rsp_tag_i[TagWidth-1 -: IdWidth];
  assign w_rsp_id_ok     = (32'(w_rsp_id) < NumReq);
  assign fpu_rsp_ready_o = ~rst_i & (w_rsp_id_ok ? rsp_ready_i[w_rsp_id] : 1'b1);
  assign w_rsp_fire      = fpu_rsp_valid_i & fpu_rsp_ready_o & w_rsp_id_ok;
  assign rsp_tag_o       = fpu_rsp_tag_i[LocalTagWidth-1:0];
  assign rsp_data_o      = fpu_rsp_data_i;

  for (genvar i = 0; i < NumReq; i++) begin : g_req
    logic w_inc;
    logic w_dec;

    assign w_eligible[i]  = req_valid_i[i] & (r_cnt[i] != CntMax);
    assign w_inc          = w_req_fire & (w_grant == IdWidth'(i));
    assign w_dec          = w_rsp_fire & (w_rsp_id == IdWidth'(i));
    assign req_ready_o[i] = w_inc;
    assign rsp_valid_o[i] = ~rst_i & fpu_rsp_valid_i & (w_rsp_id == IdWidth'(i));
    assign busy_o[i]      = ~rst_i & (r_cnt[i] != '0);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt[i] <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt[i] <= r_cnt[i] + CntWidth'(1);
      end else if (w_dec && !w_inc) begin
        r_cnt[i] <= r_cnt[i] - CntWidth'(1);
      end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_inc && !w_dec && (r_cnt[i] == CntMax)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_dec && !w_inc && (r_cnt[i] == '0)));
  end

  a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (fpu_valid_o && !fpu_ready_i) |=> $stable(fpu_data_o));
  a_rsp_id_range: assert property (@(posedge clk_i) disable iff (rst_i)
    fpu_rsp_valid_i |-> w_rsp_id_ok);

endmodule

// File: tb/tb_snitch_fpu_share_arbiter.sv
// tb/tb_snitch_fpu_share_arbiter.sv - directed scenarios plus randomized run against a behavioural model
module tb_snitch_fpu_share_arbiter;

  localparam int N    = 2;
  localparam int RDW  = 256;
  localparam int RSW  = 69;
  localparam int TW   = 7;
  localparam int MAXO = 4;
  localparam int IW   = 1;
  localparam int LT   = TW - IW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [N-1:0][RDW-1:0]  req_data;
  logic [N-1:0][LT-1:0]   req_tag;
  logic [RSW-1:0]         rsp_data;
  logic [LT-1:0]          rsp_tag;
  logic                   fpu_valid, fpu_ready, fpu_rsp_valid, fpu_rsp_ready;
  logic [RDW-1:0]         fpu_data;
  logic [TW-1:0]          fpu_tag, fpu_rsp_tag;
  logic [RSW-1:0]         fpu_rsp_data;
  int                     checks = 0;
  int                     errors = 0;

  always #5 clk = ~clk;

  snitch_fpu_share_arbiter #(
    .NumReq(N), .ReqDataWidth(RDW), .RspDataWidth(RSW), .TagWidth(TW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag),
    .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready), .fpu_data_o(fpu_data), .fpu_tag_o(fpu_tag),
    .fpu_rsp_valid_i(fpu_rsp_valid), .fpu_rsp_ready_o(fpu_rsp_ready),
    .fpu_rsp_data_i(fpu_rsp_data), .fpu_rsp_tag_i(fpu_rsp_tag),
    .busy_o(busy)
  );

  function automatic logic [RDW-1:0] rand_req();
    logic [RDW-1:0] r;
    for (int w = 0; w < RDW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RSW-1:0] rand_rsp();
    logic [RSW-1:0] r;
    r = {$urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic clr();
    req_valid = '0; req_data = '0; req_tag = '0; rsp_ready = '0;
    fpu_ready = 1'b0; fpu_rsp_valid = 1'b0; fpu_rsp_data = '0; fpu_rsp_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr();
    req_valid = '1; req_data[0] = rand_req(); fpu_ready = 1'b1;
    fpu_rsp_valid = 1'b1; rsp_ready = '1;
    @(negedge clk);
    checks++; if (fpu_valid !== 1'b0) begin errors++; $display("FAIL reset fpu_valid got %b want 0", fpu_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset rsp_valid got %b want 00", rsp_valid); end
    checks++; if (fpu_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset fpu_rsp_ready got %b want 0", fpu_rsp_ready); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset busy got %b want 00", busy); end
    tick();
    rst = 1'b0; fpu_rsp_valid = 1'b0; fpu_ready = 1'b0;
    @(negedge clk);
    checks++; if (fpu_valid !== 1'b1) begin errors++; $display("FAIL post_reset fpu_valid got %b want 1", fpu_valid); end
    checks++; if (fpu_tag[TW-1] !== 1'b0) begin errors++; $display("FAIL post_reset grant got %b want 0", fpu_tag[TW-1]); end
    checks++; if (fpu_data !== req_data[0]) begin errors++; $display("FAIL post_reset data got %h want %h", fpu_data, req_data[0]); end
    tick();
  endtask

  task automatic test_alternate();
    logic [TW-1:0] iss [10];
    logic [N-1:0]  erv;
    int            id;
    do_reset();
    for (int i = 0; i < N; i++) begin req_data[i] = rand_req(); req_tag[i] = LT'($urandom); end
    req_valid = '1; fpu_ready = 1'b1; rsp_ready = '1;
    for (int k = 0; k < 10; k++) begin
      id = k % 2;
      fpu_rsp_valid = (k >= 3);
      if (k >= 3) begin fpu_rsp_tag = iss[k-3]; fpu_rsp_data = rand_rsp(); end
      @(negedge clk);
      checks++; if (req_ready !== (2'b01 << id)) begin errors++; $display("FAIL alt_grant k=%0d got %b want %b", k, req_ready, 2'b01 << id); end
      checks++; if (fpu_tag !== {IW'(id), req_tag[id]}) begin errors++; $display("FAIL alt_tag k=%0d got %h want %h", k, fpu_tag, {IW'(id), req_tag[id]}); end
      checks++; if (fpu_data !== req_data[id]) begin errors++; $display("FAIL alt_data k=%0d got %h want %h", k, fpu_data, req_data[id]); end
      if (k >= 3) begin
        erv = 2'b01 << ((k - 3) % 2);
        checks++; if (rsp_valid !== erv) begin errors++; $display("FAIL alt_rsp_valid k=%0d got %b want %b", k, rsp_valid, erv); end
        checks++; if (rsp_tag !== iss[k-3][LT-1:0]) begin errors++; $display("FAIL alt_rsp_tag k=%0d got %h want %h", k, rsp_tag, iss[k-3][LT-1:0]); end
        checks++; if (fpu_rsp_ready !== 1'b1) begin errors++; $display("FAIL alt_rsp_ready k=%0d got %b want 1", k, fpu_rsp_ready); end
      end
      iss[k] = {IW'(id), req_tag[id]};
      tick();
      req_tag[id] = LT'($urandom); req_data[id] = rand_req();
    end
  endtask

  task automatic test_lock();
    do_reset();
    req_valid = 2'b01; req_data[0] = rand_req(); req_tag[0] = 6'd1; fpu_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_pre got %b want 01", req_ready); end
    tick();
    req_data[0] = rand_req(); req_tag[0] = 6'd2; fpu_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin req_valid = 2'b11; req_data[1] = rand_req(); req_tag[1] = 6'd3; end
      @(negedge clk);
      checks++; if (fpu_valid !== 1'b1) begin errors++; $display("FAIL lock_valid k=%0d got %b want 1", k, fpu_valid); end
      checks++; if (fpu_tag !== {1'b0, 6'd2}) begin errors++; $display("FAIL lock_hold k=%0d got %h want %h", k, fpu_tag, {1'b0, 6'd2}); end
      checks++; if (fpu_data !== req_data[0]) begin errors++; $display("FAIL lock_data k=%0d got %h want %h", k, fpu_data, req_data[0]); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL lock_ready k=%0d got %b want 00", k, req_ready); end
      tick();
    end
    fpu_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_release got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_next got %b want 10", req_ready); end
    checks++; if (fpu_tag !== {1'b1, 6'd3}) begin errors++; $display("FAIL lock_next_tag got %h want %h", fpu_tag, {1'b1, 6'd3}); end
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL lock_busy got %b want 01", busy); end
    tick();
  endtask

  task automatic test_credit();
    do_reset();
    fpu_ready = 1'b1; req_valid = 2'b01;
    for (int k = 0; k < MAXO; k++) begin
      req_tag[0] = LT'(k); req_data[0] = rand_req();
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL credit_fill k=%0d got %b want 01", k, req_ready); end
      if (k > 0) begin
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL credit_busy k=%0d got %b want 1", k, busy[0]); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (fpu_valid !== 1'b0) begin errors++; $display("FAIL credit_full_valid got %b want 0", fpu_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL credit_full_ready got %b want 00", req_ready); end
    tick();
    req_valid = 2'b11; req_data[1] = rand_req(); req_tag[1] = 6'd9;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL credit_skip got %b want 10", req_ready); end
    tick();
    req_tag[1] = 6'd10; fpu_rsp_valid = 1'b1; fpu_rsp_tag = {1'b0, 6'd0}; rsp_ready = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL credit_skip2 got %b want 10", req_ready); end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL credit_rsp got %b want 01", rsp_valid); end
    checks++; if (busy !== 2'b11) begin errors++; $display("FAIL credit_busy2 got %b want 11", busy); end
    tick();
    fpu_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL credit_regain got %b want 01", req_ready); end
    tick();
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    req_valid = 2'b10; req_tag[1] = 6'h2a; req_data[1] = rand_req(); fpu_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_issue got %b want 10", req_ready); end
    tick();
    req_valid = '0; fpu_ready = 1'b0; fpu_rsp_valid = 1'b1; fpu_rsp_tag = {1'b1, 6'h2a};
    fpu_rsp_data = rand_rsp(); rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (fpu_rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_ready k=%0d got %b want 0", k, fpu_rsp_ready); end
      checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_valid k=%0d got %b want 10", k, rsp_valid); end
      checks++; if (rsp_tag !== 6'h2a) begin errors++; $display("FAIL bp_tag k=%0d got %h want 2a", k, rsp_tag); end
      checks++; if (rsp_data !== fpu_rsp_data) begin errors++; $display("FAIL bp_data k=%0d got %h want %h", k, rsp_data, fpu_rsp_data); end
      checks++; if (busy !== 2'b10) begin errors++; $display("FAIL bp_busy k=%0d got %b want 10", k, busy); end
      tick();
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    checks++; if (fpu_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", fpu_rsp_ready); end
    tick();
    fpu_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL bp_drain got %b want 00", busy); end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_valid = 2'b01; fpu_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_data[0] = rand_req(); req_tag[0] = LT'(k);
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL same_fill k=%0d got %b want 01", k, req_ready); end
      tick();
    end
    req_data[0] = rand_req(); fpu_rsp_valid = 1'b1; fpu_rsp_tag = {1'b0, 6'd0}; rsp_ready = 2'b01;
    @(negedge clk);
    checks++; if ({req_ready, fpu_rsp_ready} !== 3'b011) begin errors++; $display("FAIL same_both got %b want 011", {req_ready, fpu_rsp_ready}); end
    tick();
    fpu_rsp_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_data[0] = rand_req();
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL same_refill k=%0d got %b want 01", k, req_ready); end
      tick();
    end
    @(negedge clk);
    checks++; if ({fpu_valid, req_ready} !== 3'b000) begin errors++; $display("FAIL same_full got %b want 000", {fpu_valid, req_ready}); end
    tick();
  endtask

  task automatic test_reset_inflight();
    logic [N-1:0] exp_rr;
    do_reset();
    req_valid = 2'b11; fpu_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_rr = 2'b01 << (k % 2);
      @(negedge clk);
      checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL rif_issue k=%0d got %b want %b", k, req_ready, exp_rr); end
      tick();
    end
    fpu_ready = 1'b0;
    @(negedge clk);
    checks++; if ({fpu_valid, fpu_tag[TW-1]} !== 2'b11) begin errors++; $display("FAIL rif_lock got %b want 11", {fpu_valid, fpu_tag[TW-1]}); end
    tick();
    rst = 1'b1; fpu_ready = 1'b1; fpu_rsp_valid = 1'b1; fpu_rsp_tag = '0; rsp_ready = '1;
    @(negedge clk);
    checks++; if ({fpu_valid, req_ready, rsp_valid, fpu_rsp_ready, busy} !== 8'h00) begin
      errors++; $display("FAIL rif_outputs got %b want 0", {fpu_valid, req_ready, rsp_valid, fpu_rsp_ready, busy});
    end
    tick();
    rst = 1'b0; fpu_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rif_first_grant got %b want 01", req_ready); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL rif_busy got %b want 00", busy); end
    tick();
    @(negedge clk);
    checks++; if ({busy, req_ready} !== 4'b0110) begin errors++; $display("FAIL rif_after got %b want 0110", {busy, req_ready}); end
    tick();
  endtask

  // Model: a grant offered without a handshake is owed to that requester; otherwise the
  // first requester with spare credit, scanning from one past the last accepted id, wins.
  task automatic test_random();
    int            m_cnt [N];
    int            m_next;
    bit            m_owed;
    int            m_owed_id;
    logic [TW-1:0] q_tag [$];
    int            q_cyc [$];
    bit            cur;
    logic [TW-1:0] cur_tag;
    logic [RSW-1:0] cur_data;
    bit            ev, acc;
    int            win, rid, j;
    logic [N-1:0]  e_rr, e_rv, e_busy;
    bit            e_rsp_rdy;
    do_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_next = 0; m_owed = 0; m_owed_id = 0; cur = 0; cur_tag = '0; cur_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 6) begin
          req_valid[i] = 1'b1; req_data[i] = rand_req(); req_tag[i] = LT'($urandom);
        end
      end
      fpu_ready = ($urandom_range(0, 9) < 7);
      rsp_ready = N'($urandom);
      if (!cur && q_tag.size() > 0 && $urandom_range(0, 3) != 0) begin
        j = $urandom_range(0, q_tag.size() - 1);
        if (cyc - q_cyc[j] >= 3) begin
          cur = 1; cur_tag = q_tag[j]; cur_data = rand_rsp();
          q_tag.delete(j); q_cyc.delete(j);
        end
      end
      fpu_rsp_valid = cur; fpu_rsp_tag = cur_tag; fpu_rsp_data = cur_data;

      ev = 0; win = 0;
      if (m_owed) begin ev = 1; win = m_owed_id; end
      else begin
        for (int d = 0; d < N; d++) begin
          int c;
          c = (m_next + d) % N;
          if (!ev && req_valid[c] && m_cnt[c] < MAXO) begin ev = 1; win = c; end
        end
      end
      rid = int'(cur_tag >> LT);
      e_rr = (ev && fpu_ready) ? (N'(1) << win) : '0;
      e_rv = cur ? (N'(1) << rid) : '0;
      e_rsp_rdy = rsp_ready[rid];
      for (int i = 0; i < N; i++) e_busy[i] = (m_cnt[i] != 0);
      if (rst) begin ev = 0; e_rr = '0; e_rv = '0; e_rsp_rdy = 0; e_busy = '0; end

      @(negedge clk);
      checks++; if (fpu_valid !== ev) begin errors++; $display("FAIL rnd_fpu_valid cyc=%0d got %b want %b", cyc, fpu_valid, ev); end
      checks++; if (req_ready !== e_rr) begin errors++; $display("FAIL rnd_req_ready cyc=%0d got %b want %b", cyc, req_ready, e_rr); end
      checks++; if (rsp_valid !== e_rv) begin errors++; $display("FAIL rnd_rsp_valid cyc=%0d got %b want %b", cyc, rsp_valid, e_rv); end
      checks++; if (fpu_rsp_ready !== e_rsp_rdy) begin errors++; $display("FAIL rnd_rsp_ready cyc=%0d got %b want %b", cyc, fpu_rsp_ready, e_rsp_rdy); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, busy, e_busy); end
      if (ev) begin
        checks++; if (fpu_tag !== {IW'(win), req_tag[win]}) begin errors++; $display("FAIL rnd_fpu_tag cyc=%0d got %h want %h", cyc, fpu_tag, {IW'(win), req_tag[win]}); end
        checks++; if (fpu_data !== req_data[win]) begin errors++; $display("FAIL rnd_fpu_data cyc=%0d got %h want %h", cyc, fpu_data, req_data[win]); end
      end
      if (cur && !rst) begin
        checks++; if (rsp_tag !== cur_tag[LT-1:0]) begin errors++; $display("FAIL rnd_rsp_tag cyc=%0d got %h want %h", cyc, rsp_tag, cur_tag[LT-1:0]); end
        checks++; if (rsp_data !== cur_data) begin errors++; $display("FAIL rnd_rsp_data cyc=%0d got %h want %h", cyc, rsp_data, cur_data); end
      end

      acc = 0;
      if (rst) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_next = 0; m_owed = 0; cur = 0;
        q_tag.delete(); q_cyc.delete();
      end else begin
        if (ev && fpu_ready) begin
          acc = 1; m_cnt[win]++; m_next = (win + 1) % N; m_owed = 0;
          q_tag.push_back({IW'(win), req_tag[win]}); q_cyc.push_back(cyc);
        end else if (ev) begin
          m_owed = 1; m_owed_id = win;
        end
        if (cur && e_rsp_rdy) begin m_cnt[rid]--; cur = 0; end
      end
      tick();
      if (rst) req_valid = '0;
      else if (acc) req_valid[win] = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_credit();
    test_rsp_backpressure();
    test_same_cycle();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
